// File: rtl/pwd_rom_arbiter.sv
// pwd_rom_arbiter: shares one synchronous password ROM between NREQ requesters.
// Round-robin arbitration, one outstanding read, ROM latency hidden behind a
// gnt / rd_valid handshake. All outputs are registered.
// Optional feature: define ARB_LOCK_EN to add the lock input, which lets the
// previous owner keep the ROM for consecutive reads (e.g. a 4-digit fetch).
module pwd_rom_arbiter #(
  parameter int NREQ   = 2,
  parameter int AW     = 2,
  parameter int DW     = 4,
  parameter int RD_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
`ifdef ARB_LOCK_EN
  input  logic [NREQ-1:0]    lock,
`endif
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rd_valid,
  output logic [DW-1:0]      rd_data,
  output logic [AW-1:0]      rom_addr,
  input  logic [DW-1:0]      rom_data,
  output logic               busy
);

  // Pointer/owner width; kept at least one bit so NREQ==1 still elaborates.
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // Wait counter only ever holds values up to RD_LAT-1.
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

  state_t            state_reg, state_next;
  logic [NREQ-1:0]   gnt_reg, gnt_next;
  logic [NREQ-1:0]   rd_valid_reg, rd_valid_next;
  logic [DW-1:0]     rd_data_reg, rd_data_next;
  logic [AW-1:0]     rom_addr_reg, rom_addr_next;
  logic              busy_reg, busy_next;
  logic [PW-1:0]     owner_reg, owner_next;
  logic [PW-1:0]     rr_ptr_reg, rr_ptr_next;
  logic [CW-1:0]     cnt_reg, cnt_next;

  logic              win_found;
  logic              lock_hold;
  logic [PW-1:0]     win_idx;
  logic [PW-1:0]     win_succ;
  logic [AW-1:0]     addr_arr [NREQ];

  // Unpack the per-requester address slices.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_addr
      assign addr_arr[gi] = req_addr[gi*AW +: AW];
    end
  endgenerate

  // Round-robin winner search upward from rr_ptr with wrap; lock may override.
  always_comb begin
    int sum;
    int succ;
    logic [PW-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    lock_hold = 1'b0;
    sum       = 0;
    cand      = '0;
    for (int off = 0; off < NREQ; off++) begin
      sum = int'(rr_ptr_reg) + off;
      if (sum >= NREQ) sum = sum - NREQ;
      cand = PW'(sum);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
`ifdef ARB_LOCK_EN
    if (lock[owner_reg] && req[owner_reg]) begin
      win_found = 1'b1;
      win_idx   = owner_reg;
      lock_hold = 1'b1;
    end
`endif
    succ = int'(win_idx) + 1;
    if (succ >= NREQ) succ = 0;
    win_succ = PW'(succ);
  end

  // Next-state and next-output logic for the IDLE/ISSUE/WAIT/CAPTURE sequence.
  always_comb begin
    state_next    = state_reg;
    gnt_next      = '0;
    rd_valid_next = '0;
    rd_data_next  = rd_data_reg;
    rom_addr_next = rom_addr_reg;
    owner_next    = owner_reg;
    rr_ptr_next   = rr_ptr_reg;
    cnt_next      = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          rom_addr_next     = addr_arr[win_idx];
          gnt_next[win_idx] = 1'b1;
          owner_next        = win_idx;
          if (!lock_hold) rr_ptr_next = win_succ;
          state_next        = ISSUE;
        end
      end
      ISSUE: begin
        cnt_next   = CW'(RD_LAT - 1);
        // With single-cycle ROM latency the data is already valid next cycle.
        state_next = (RD_LAT == 1) ? CAPTURE : WAIT;
      end
      WAIT: begin
        cnt_next = cnt_reg - CW'(1);
        if (cnt_reg <= CW'(1)) state_next = CAPTURE;
      end
      CAPTURE: begin
        rd_data_next            = rom_data;
        rd_valid_next[owner_reg] = 1'b1;
        state_next              = IDLE;
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  // Register state and all outputs; reset aborts any read in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      gnt_reg      <= '0;
      rd_valid_reg <= '0;
      rd_data_reg  <= '0;
      rom_addr_reg <= '0;
      busy_reg     <= 1'b0;
      owner_reg    <= '0;
      rr_ptr_reg   <= '0;
      cnt_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      gnt_reg      <= gnt_next;
      rd_valid_reg <= rd_valid_next;
      rd_data_reg  <= rd_data_next;
      rom_addr_reg <= rom_addr_next;
      busy_reg     <= busy_next;
      owner_reg    <= owner_next;
      rr_ptr_reg   <= rr_ptr_next;
      cnt_reg      <= cnt_next;
    end
  end

  assign gnt      = gnt_reg;
  assign rd_valid = rd_valid_reg;
  assign rd_data  = rd_data_reg;
  assign rom_addr = rom_addr_reg;
  assign busy     = busy_reg;

endmodule

// File: tb/tb_pwd_rom_arbiter.sv
// tb_pwd_rom_arbiter: directed bench for pwd_rom_arbiter (NREQ=2, RD_LAT=2)
// with a 2-cycle-latency ROM model and a scoreboard of expected reads.
// Define ARB_LOCK_EN to also exercise the lock port.
module tb_pwd_rom_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] req = '0;
  logic [1:0] a0 = '0, a1 = '0;
  logic [3:0] req_addr;
  logic [1:0] gnt, rd_valid;
  logic [3:0] rd_data;
  logic [1:0] rom_addr;
  logic [3:0] rom_data;
  logic       busy;
  logic [3:0] rom_s1;
`ifdef ARB_LOCK_EN
  logic [1:0] lock = '0;
`endif

  typedef struct {
    logic [1:0] who;
    logic [3:0] data;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int last_n = 0;

  assign req_addr = {a1, a0};

  always #5 clk = ~clk;

  pwd_rom_arbiter #(.NREQ(2), .AW(2), .DW(4), .RD_LAT(2)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr),
`ifdef ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt(gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy)
  );

  // Reference ROM contents.
  function automatic logic [3:0] rom_val(input logic [1:0] a);
    case (a)
      2'd0: rom_val = 4'h3;
      2'd1: rom_val = 4'h9;
      2'd2: rom_val = 4'h1;
      default: rom_val = 4'h7;
    endcase
  endfunction

  // Synchronous ROM with two cycles of read latency.
  always @(posedge clk) begin
    rom_s1   <= rom_val(rom_addr);
    rom_data <= rom_s1;
  end

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sample #1 after the edge, retire any completed read.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (rd_valid !== 2'b00) begin
      if (sb.size() == 0) begin
        chk(rd_valid, 0, "unexpected_rd_valid");
      end else begin
        e = sb.pop_front();
        chk(rd_valid, e.who, "rd_valid_owner");
        chk(rd_data, e.data, "rd_data");
        $display("read: owner=%b data=%h expected owner=%b data=%h", rd_valid, rd_data, e.who, e.data);
      end
    end
  endtask

  // Wait (bounded) for a grant, check it, and record the read it starts.
  task automatic wait_gnt(input logic [1:0] exp_g, input logic [3:0] exp_d, input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (gnt === 2'b00 && n < 20);
    last_n = n;
    chk(gnt, exp_g, tag);
    if (gnt === exp_g) sb.push_back('{exp_g, exp_d});
    $display("grant: gnt=%b expected=%b after %0d cycles", gnt, exp_g, n);
  endtask

  // Wait (bounded) until the arbiter is idle and every expected read arrived.
  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy !== 1'b0 || sb.size() != 0) && n < 20) begin
      tick();
      n++;
    end
    chk((n < 20) ? 1 : 0, 1, tag);
  endtask

  initial begin
    // Reset state
    tick();
    chk(gnt, 0, "rst_gnt");
    chk(rd_valid, 0, "rst_rd_valid");
    chk(rd_data, 0, "rst_rd_data");
    chk(rom_addr, 0, "rst_rom_addr");
    chk(busy, 0, "rst_busy");
    tick();
    rst = 1'b1;
    tick();

    // Single read: gnt in cycle 1, busy cycles 1-3, rd_valid in cycle 4
    a0 = 2'd2;
    req = 2'b01;
    wait_gnt(2'b01, rom_val(2'd2), "single_gnt");
    chk(last_n, 1, "single_gnt_latency");
    chk(busy, 1, "single_busy_c1");
    req = 2'b00;
    tick();
    chk(busy, 1, "single_busy_c2");
    tick();
    chk(busy, 1, "single_busy_c3");
    chk(rd_valid, 0, "single_no_early_valid");
    tick();
    chk(rd_valid, 2'b01, "single_valid_c4");
    chk(rd_data, 4'h1, "single_data_c4");
    chk(busy, 0, "single_busy_c4");
    wait_idle("single_idle");

    // Address hold: addr0 changed during WAIT must not reach the ROM
    a0 = 2'd3;
    req = 2'b01;
    wait_gnt(2'b01, rom_val(2'd3), "hold_gnt");
    req = 2'b00;
    chk(rom_addr, 3, "hold_rom_addr_issue");
    tick();
    a0 = 2'd0;
    tick();
    chk(rom_addr, 3, "hold_rom_addr_after_change");
    wait_idle("hold_idle");
    chk(rom_addr, 3, "hold_rom_addr_idle");

    // Reset mid-read: no rd_valid, all outputs cleared
    a0 = 2'd1;
    req = 2'b01;
    tick();
    chk(gnt, 2'b01, "midrst_gnt");
    req = 2'b00;
    tick();
    rst = 1'b0;
    tick();
    chk(gnt, 0, "midrst_gnt_clr");
    chk(rd_valid, 0, "midrst_rd_valid");
    chk(rd_data, 0, "midrst_rd_data");
    chk(rom_addr, 0, "midrst_rom_addr");
    chk(busy, 0, "midrst_busy");
    rst = 1'b1;
    tick();
    tick();
    tick();

    // Contention after reset: grants alternate 01, 10, 01
    a0 = 2'd0;
    a1 = 2'd3;
    req = 2'b11;
    wait_gnt(2'b01, rom_val(2'd0), "cont_gnt0");
    wait_gnt(2'b10, rom_val(2'd3), "cont_gnt1");
    wait_gnt(2'b01, rom_val(2'd0), "cont_gnt2");
    req = 2'b00;
    wait_idle("cont_idle");

    // Withdrawal: req1 raised while busy and dropped before IDLE
    a0 = 2'd2;
    req = 2'b01;
    wait_gnt(2'b01, rom_val(2'd2), "wd_gnt0");
    req = 2'b00;
    tick();
    a1 = 2'd3;
    req = 2'b10;
    tick();
    chk(gnt, 0, "wd_no_gnt_c3");
    req = 2'b00;
    tick();
    chk(gnt, 0, "wd_no_gnt_c4");
    tick();
    chk(gnt, 0, "wd_no_gnt_c5");
    wait_idle("wd_idle");
    // rr_ptr still points at requester 1
    a0 = 2'd0;
    a1 = 2'd1;
    req = 2'b11;
    wait_gnt(2'b10, rom_val(2'd1), "wd_ptr_gnt1");
    req = 2'b00;
    wait_idle("wd_ptr_idle");

`ifdef ARB_LOCK_EN
    // Lock: requester 0 keeps the ROM for four reads, then requester 1 wins
    a0 = 2'd0;
    req = 2'b01;
    wait_gnt(2'b01, rom_val(2'd0), "lock_pre_gnt");
    req = 2'b00;
    wait_idle("lock_pre_idle");
    a0 = 2'd0;
    a1 = 2'd2;
    lock = 2'b01;
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(2'b01, rom_val(a0), "lock_gnt0");
      a0 = a0 + 2'd1;
      if (k == 3) lock = 2'b00;
    end
    wait_gnt(2'b10, rom_val(2'd2), "lock_release_gnt1");
    req = 2'b00;
    wait_idle("lock_idle");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
